// File: rtl/conv_pkg.sv
// Shared mode encodings, fixed kernels and width helpers for the 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SHARP = 2'd2,
        MODE_USER  = 2'd3
    } mode_e;

    localparam int KERNEL_TAPS = 9;

    typedef int kernel_t [KERNEL_TAPS];

    // Row-major, tap 0 is top-left of the window.
    localparam kernel_t KERN_PASS  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    localparam kernel_t KERN_GAUSS = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    localparam kernel_t KERN_SHARP = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

    localparam logic [3:0] SHIFT_PASS  = 4'd0;
    localparam logic [3:0] SHIFT_GAUSS = 4'd4;
    localparam logic [3:0] SHIFT_SHARP = 4'd0;

    // Nine products of a signed coefficient and a zero-extended pixel, plus growth headroom.
    function automatic int sum_width(input int pixel_w, input int coef_w);
        return pixel_w + coef_w + 5;
    endfunction

endpackage

// File: rtl/conv3x3_cfg.sv
// Kernel configuration: user shadow registers, committed active config and the
// mode decode that presents the active kernel and shift to the datapath.
module conv3x3_cfg
    import conv_pkg::*;
#(
    parameter int COEF_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [1:0]                    i_mode,
    input  logic                          i_coef_we,
    input  logic [3:0]                    i_coef_addr,
    input  logic [COEF_W-1:0]             i_coef_data,
    input  logic [3:0]                    i_user_shift,
    input  logic                          i_cfg_update,
    output logic [KERNEL_TAPS*COEF_W-1:0] o_kernel,
    output logic [3:0]                    o_shift
);

    logic [COEF_W-1:0] shadow_kernel [KERNEL_TAPS];
    logic [COEF_W-1:0] user_kernel   [KERNEL_TAPS];
    mode_e             active_mode;
    logic [3:0]        user_shift;

    // A commit copies the shadow as it stood before any write landing in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                shadow_kernel[k] <= '0;
                user_kernel[k]   <= '0;
            end
            active_mode <= MODE_PASS;
            user_shift  <= '0;
        end else begin
            if (i_coef_we && (i_coef_addr < 4'(KERNEL_TAPS))) begin
                shadow_kernel[i_coef_addr] <= i_coef_data;
            end
            if (i_cfg_update) begin
                active_mode <= mode_e'(i_mode);
                user_shift  <= i_user_shift;
                for (int k = 0; k < KERNEL_TAPS; k++) begin
                    user_kernel[k] <= shadow_kernel[k];
                end
            end
        end
    end

    always_comb begin
        o_kernel = '0;
        o_shift  = SHIFT_PASS;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            case (active_mode)
                MODE_PASS:  o_kernel[k*COEF_W +: COEF_W] = COEF_W'(KERN_PASS[k]);
                MODE_GAUSS: o_kernel[k*COEF_W +: COEF_W] = COEF_W'(KERN_GAUSS[k]);
                MODE_SHARP: o_kernel[k*COEF_W +: COEF_W] = COEF_W'(KERN_SHARP[k]);
                default:    o_kernel[k*COEF_W +: COEF_W] = user_kernel[k];
            endcase
        end
        case (active_mode)
            MODE_PASS:  o_shift = SHIFT_PASS;
            MODE_GAUSS: o_shift = SHIFT_GAUSS;
            MODE_SHARP: o_shift = SHIFT_SHARP;
            default:    o_shift = user_shift;
        endcase
    end

endmodule

// File: rtl/conv3x3_filter.sv
// Three-stage 3x3 convolution: multiply, sum, then round/shift/clamp into the
// output register, with a single global stall driven by downstream backpressure.
module conv3x3_filter
    import conv_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int COEF_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [9*PIXEL_W-1:0] i_pixel_data,
    input  logic                 i_pixel_data_valid,
    output logic                 o_pixel_ready,
    output logic [PIXEL_W-1:0]   o_convolved_data,
    output logic                 o_convolved_data_valid,
    input  logic                 i_ready,
    input  logic [1:0]           i_mode,
    input  logic                 i_coef_we,
    input  logic [3:0]           i_coef_addr,
    input  logic [COEF_W-1:0]    i_coef_data,
    input  logic [3:0]           i_user_shift,
    input  logic                 i_cfg_update,
    output logic [CNT_W-1:0]     o_clip_count
);

    localparam int PROD_W = PIXEL_W + COEF_W + 1;
    localparam int SUM_W  = sum_width(PIXEL_W, COEF_W);
    localparam int RND_W  = SUM_W + 1;

    logic                          en;
    logic [KERNEL_TAPS*COEF_W-1:0] kernel;
    logic [3:0]                    kernel_shift;

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod [KERNEL_TAPS];
    logic [3:0]               s1_shift;
    logic                     s2_valid;
    logic signed [SUM_W-1:0]  s2_sum;
    logic [3:0]               s2_shift;

    logic signed [PROD_W-1:0] prod_next [KERNEL_TAPS];
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [RND_W-1:0]  rounded;
    logic signed [RND_W-1:0]  shifted;
    logic [PIXEL_W-1:0]       pixel_next;
    logic                     clip_next;

    assign en            = !o_convolved_data_valid || i_ready;
    assign o_pixel_ready = en;

    conv3x3_cfg #(
        .COEF_W (COEF_W)
    ) u_cfg (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mode       (i_mode),
        .i_coef_we    (i_coef_we),
        .i_coef_addr  (i_coef_addr),
        .i_coef_data  (i_coef_data),
        .i_user_shift (i_user_shift),
        .i_cfg_update (i_cfg_update),
        .o_kernel     (kernel),
        .o_shift      (kernel_shift)
    );

    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            prod_next[k] = $signed({{(PROD_W-COEF_W){kernel[k*COEF_W+COEF_W-1]}}, kernel[k*COEF_W +: COEF_W]})
                         * $signed({{(PROD_W-PIXEL_W){1'b0}}, i_pixel_data[k*PIXEL_W +: PIXEL_W]});
        end
        sum_next = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            sum_next = sum_next + $signed({{(SUM_W-PROD_W){s1_prod[k][PROD_W-1]}}, s1_prod[k]});
        end
    end

    // Round half up before the arithmetic shift; one extra bit keeps the bias from overflowing.
    always_comb begin
        rounded = $signed({s2_sum[SUM_W-1], s2_sum});
        if (s2_shift != 4'd0) begin
            rounded = rounded + (RND_W'(1) <<< (s2_shift - 4'd1));
        end
        shifted    = rounded >>> s2_shift;
        pixel_next = shifted[PIXEL_W-1:0];
        clip_next  = 1'b0;
        if (shifted[RND_W-1]) begin
            pixel_next = '0;
            clip_next  = 1'b1;
        end else if (|shifted[RND_W-2:PIXEL_W]) begin
            pixel_next = '1;
            clip_next  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                s1_prod[k] <= '0;
            end
            s2_valid               <= 1'b0;
            s2_sum                 <= '0;
            s2_shift               <= '0;
            o_convolved_data_valid <= 1'b0;
            o_convolved_data       <= '0;
        end else if (en) begin
            s1_valid               <= i_pixel_data_valid;
            s1_prod                <= prod_next;
            s1_shift               <= kernel_shift;
            s2_valid               <= s1_valid;
            s2_sum                 <= sum_next;
            s2_shift               <= s1_shift;
            o_convolved_data_valid <= s2_valid;
            o_convolved_data       <= pixel_next;
        end
    end

    // A config commit restarts the clip statistics, even if a clip lands in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_clip_count <= '0;
        end else if (i_cfg_update) begin
            o_clip_count <= '0;
        end else if (en && s2_valid && clip_next && (o_clip_count != '1)) begin
            o_clip_count <= o_clip_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter: a negedge monitor keeps a reference model of the
// committed config, queues expected pixels on accept and checks them on transfer.
module tb_conv3x3_filter;

    localparam int PIXEL_W = 8;
    localparam int COEF_W  = 8;
    localparam int CNT_W   = 16;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [9*PIXEL_W-1:0] i_pixel_data;
    logic                 i_pixel_data_valid;
    logic                 o_pixel_ready;
    logic [PIXEL_W-1:0]   o_convolved_data;
    logic                 o_convolved_data_valid;
    logic                 i_ready;
    logic [1:0]           i_mode;
    logic                 i_coef_we;
    logic [3:0]           i_coef_addr;
    logic [COEF_W-1:0]    i_coef_data;
    logic [3:0]           i_user_shift;
    logic                 i_cfg_update;
    logic [CNT_W-1:0]     o_clip_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [$];
    int         m_mode;
    int         m_shift;
    int         m_active [9];
    int         m_shadow [9];
    logic       stalled = 1'b0;
    logic [7:0] held_data;

    conv3x3_filter #(
        .PIXEL_W (PIXEL_W),
        .COEF_W  (COEF_W),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_pixel_data           (i_pixel_data),
        .i_pixel_data_valid     (i_pixel_data_valid),
        .o_pixel_ready          (o_pixel_ready),
        .o_convolved_data       (o_convolved_data),
        .o_convolved_data_valid (o_convolved_data_valid),
        .i_ready                (i_ready),
        .i_mode                 (i_mode),
        .i_coef_we              (i_coef_we),
        .i_coef_addr            (i_coef_addr),
        .i_coef_data            (i_coef_data),
        .i_user_shift           (i_user_shift),
        .i_cfg_update           (i_cfg_update),
        .o_clip_count           (o_clip_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model_pixel(input logic [71:0] win, input int mode,
                                               input int shift, input int user_k [9]);
        int gauss [9];
        int sharp [9];
        int sum;
        int c;
        int s;
        int y;
        gauss = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        sharp = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
        sum = 0;
        for (int i = 0; i < 9; i++) begin
            case (mode)
                0:       c = (i == 4) ? 1 : 0;
                1:       c = gauss[i];
                2:       c = sharp[i];
                default: c = user_k[i];
            endcase
            sum += c * int'(win[i*8 +: 8]);
        end
        s = (mode == 1) ? 4 : ((mode == 3) ? shift : 0);
        y = (s > 0) ? ((sum + (1 << (s - 1))) >>> s) : sum;
        if (y < 0) y = 0;
        if (y > 255) y = 255;
        return 8'(y);
    endfunction

    function automatic logic [71:0] uniform_win(input logic [7:0] p);
        return {9{p}};
    endfunction

    function automatic logic [71:0] centre_win(input logic [7:0] centre, input logic [7:0] others);
        logic [71:0] w;
        w = {9{others}};
        w[32 +: 8] = centre;
        return w;
    endfunction

    function automatic logic [71:0] random_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // Reference model and scoreboard; commit sees the shadow before a same-cycle write.
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            m_mode  = 0;
            m_shift = 0;
            for (int k = 0; k < 9; k++) begin
                m_active[k] = 0;
                m_shadow[k] = 0;
            end
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("stall_valid", 32'(o_convolved_data_valid), 32'd1);
                checkOutput("stall_data", 32'(o_convolved_data), 32'(held_data));
            end
            if (o_convolved_data_valid && !i_ready) begin
                checkOutput("stall_ready_low", 32'(o_pixel_ready), 32'd0);
            end
            if (o_convolved_data_valid && i_ready) begin
                if (exp_q.size() == 0) checkOutput("unexpected_out", 32'(exp_q.size()), 32'd1);
                else checkOutput("out_data", 32'(o_convolved_data), 32'(exp_q.pop_front()));
            end
            if (i_pixel_data_valid && o_pixel_ready) begin
                exp_q.push_back(model_pixel(i_pixel_data, m_mode, m_shift, m_active));
            end
            if (i_cfg_update) begin
                m_mode  = int'(i_mode);
                m_shift = int'(i_user_shift);
                for (int k = 0; k < 9; k++) m_active[k] = m_shadow[k];
            end
            if (i_coef_we && (i_coef_addr <= 4'd8)) begin
                m_shadow[i_coef_addr] = int'($signed(i_coef_data));
            end
            stalled   = o_convolved_data_valid && !i_ready;
            held_data = o_convolved_data;
        end
    end

    task automatic applyStimulus(input logic [71:0] win);
        int tries;
        tries = 0;
        i_pixel_data       = win;
        i_pixel_data_valid = 1'b1;
        @(negedge i_clk);
        while (!o_pixel_ready && tries < 50) begin
            @(negedge i_clk);
            tries++;
        end
        checkOutput("accept", 32'(o_pixel_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic commitConfig(input int mode, input int shift);
        i_mode       = 2'(mode);
        i_user_shift = 4'(shift);
        i_cfg_update = 1'b1;
        @(posedge i_clk);
        #1;
        i_cfg_update = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input int val);
        i_coef_addr = 4'(addr);
        i_coef_data = 8'(val);
        i_coef_we   = 1'b1;
        @(posedge i_clk);
        #1;
        i_coef_we = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        i_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [71:0] stream_win [20];
        int          ready_pat [4];
        int          idx;
        int          cyc;

        ready_pat          = '{1, 0, 0, 1};
        i_rst              = 1'b1;
        i_pixel_data       = '0;
        i_pixel_data_valid = 1'b0;
        i_ready            = 1'b1;
        i_mode             = 2'd0;
        i_coef_we          = 1'b0;
        i_coef_addr        = '0;
        i_coef_data        = '0;
        i_user_shift       = '0;
        i_cfg_update       = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", 32'(o_convolved_data_valid), 32'd0);
        checkOutput("rst_data", 32'(o_convolved_data), 32'd0);
        checkOutput("rst_clip", 32'(o_clip_count), 32'd0);
        checkOutput("rst_ready", 32'(o_pixel_ready), 32'd1);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Passthrough with a three-cycle latency.
        begin
            logic [71:0] w;
            w = random_win();
            w[32 +: 8] = 8'd77;
            applyStimulus(w);
        end
        checkOutput("lat_e0_valid", 32'(o_convolved_data_valid), 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput("lat_e1_valid", 32'(o_convolved_data_valid), 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput("lat_e2_valid", 32'(o_convolved_data_valid), 32'd1);
        checkOutput("lat_e2_data", 32'(o_convolved_data), 32'd77);
        waitDrain("pass");
        checkOutput("pass_clip", 32'(o_clip_count), 32'd0);

        commitConfig(1, 0);
        applyStimulus(uniform_win(8'd100));
        applyStimulus(centre_win(8'd255, 8'd0));
        waitDrain("gauss");
        checkOutput("gauss_clip", 32'(o_clip_count), 32'd0);

        commitConfig(2, 0);
        applyStimulus(centre_win(8'd255, 8'd0));
        waitDrain("sharp_hi");
        checkOutput("sharp_clip_hi", 32'(o_clip_count), 32'd1);
        applyStimulus(centre_win(8'd0, 8'd255));
        waitDrain("sharp_lo");
        checkOutput("sharp_clip_lo", 32'(o_clip_count), 32'd2);

        for (int a = 0; a < 9; a++) writeCoef(a, 1);
        commitConfig(3, 3);
        checkOutput("commit_clears_clip", 32'(o_clip_count), 32'd0);
        applyStimulus(uniform_win(8'd8));
        waitDrain("user_ones");

        // Window, coefficient write and commit all in one cycle.
        i_pixel_data       = uniform_win(8'd8);
        i_pixel_data_valid = 1'b1;
        i_coef_addr        = 4'd4;
        i_coef_data        = 8'd5;
        i_coef_we          = 1'b1;
        i_mode             = 2'd3;
        i_user_shift       = 4'd3;
        i_cfg_update       = 1'b1;
        @(negedge i_clk);
        checkOutput("same_cycle_accept", 32'(o_pixel_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_pixel_data_valid = 1'b0;
        i_coef_we          = 1'b0;
        i_cfg_update       = 1'b0;
        applyStimulus(uniform_win(8'd8));
        waitDrain("user_old_coef");
        writeCoef(13, 100);
        commitConfig(3, 3);
        applyStimulus(uniform_win(8'd8));
        waitDrain("user_new_coef");

        for (int a = 0; a < 9; a++) writeCoef(a, -128);
        commitConfig(3, 15);
        applyStimulus(uniform_win(8'd255));
        waitDrain("user_worst_neg");
        checkOutput("worst_neg_clip", 32'(o_clip_count), 32'd1);
        for (int a = 0; a < 9; a++) writeCoef(a, 127);
        commitConfig(3, 15);
        applyStimulus(uniform_win(8'd255));
        waitDrain("user_worst_pos");
        checkOutput("worst_pos_clip", 32'(o_clip_count), 32'd0);

        // Streaming under a 1,0,0,1 downstream ready pattern.
        commitConfig(1, 0);
        for (int i = 0; i < 20; i++) stream_win[i] = random_win();
        idx = 0;
        cyc = 0;
        while (idx < 20 && cyc < 400) begin
            i_ready            = (ready_pat[cyc % 4] != 0);
            i_pixel_data       = stream_win[idx];
            i_pixel_data_valid = 1'b1;
            @(negedge i_clk);
            if (o_pixel_ready) idx++;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_pixel_data_valid = 1'b0;
        checkOutput("stream_all_sent", 32'(idx), 32'd20);
        waitDrain("stream");

        // Reset with three samples in flight, back to passthrough afterwards.
        for (int i = 0; i < 3; i++) begin
            i_pixel_data       = random_win();
            i_pixel_data_valid = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_pixel_data_valid = 1'b0;
        checkOutput("inflight_valid", 32'(o_convolved_data_valid), 32'd1);
        #1;
        i_rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(o_convolved_data_valid), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checkOutput("no_stale_out", 32'(o_convolved_data_valid), 32'd0);
        end
        @(posedge i_clk);
        #1;
        applyStimulus(centre_win(8'd77, 8'd50));
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("post_rst_valid", 32'(o_convolved_data_valid), 32'd1);
        checkOutput("post_rst_pass", 32'(o_convolved_data), 32'd77);
        waitDrain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv3x3_filter.md
Name: conv3x3_filter

Overview:
- Parametrised 3x3 convolution engine for the PYNQ image pipeline.
- Sits between the line-buffer window generator (9-pixel window in) and the output DMA/stream (one pixel out).
- Runtime-selectable kernels: passthrough, Gaussian, sharpen, or a user-loaded kernel.
- Adds signed arithmetic, rounding shift, saturation to the pixel range, ready/valid backpressure and a clip counter.

Parameters:
- PIXEL_W, 8, unsigned pixel width (in and out)
- COEF_W, 8, signed two's-complement coefficient width
- CNT_W, 16, clip counter width

Ports:
- i_clk  in  1  clock, all logic on the rising edge
- i_rst  in  1  asynchronous active-high reset
- i_pixel_data  in  9*PIXEL_W  window; pixel k at [k*PIXEL_W +: PIXEL_W], k=0 top-left, row-major
- i_pixel_data_valid  in  1  window valid
- o_pixel_ready  out  1  engine accepts a window this cycle
- o_convolved_data  out  PIXEL_W  filtered pixel
- o_convolved_data_valid  out  1  output valid
- i_ready  in  1  downstream accepts output
- i_mode  in  2  0 passthrough, 1 Gaussian, 2 sharpen, 3 user
- i_coef_we  in  1  write user shadow coefficient
- i_coef_addr  in  4  coefficient index 0..8
- i_coef_data  in  COEF_W  signed coefficient
- i_user_shift  in  4  right-shift for user mode
- i_cfg_update  in  1  one-cycle pulse: latch i_mode, shadow kernel and i_user_shift into active config, clear clip counter
- o_clip_count  out  CNT_W  saturating count of clamped output pixels

Behaviour:
- Reset (async, i_rst=1):
  - o_convolved_data=0, o_convolved_data_valid=0, o_clip_count=0.
  - Active mode=0 (passthrough); shadow and active user kernels all 0; user shift 0.
  - All pipeline valid bits cleared; in-flight data discarded.
  - o_pixel_ready=1 after reset.
- Fixed kernels and shifts:
  - Passthrough: centre coefficient 1, all others 0; shift 0.
  - Gaussian: 1 2 1 / 2 4 2 / 1 2 1; shift 4.
  - Sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0; shift 0.
- Pipeline: 3 stages, latency 3 cycles from accept to o_convolved_data_valid when unstalled.
  - S1: nine signed products, coef * {1'b0,pixel}.
  - S2: signed sum of the products, width PIXEL_W+COEF_W+5.
  - S3: rounding shift, clamp, output register.
- Handshake:
  - Global advance en = !o_convolved_data_valid | i_ready; o_pixel_ready = en.
  - A window is accepted when i_pixel_data_valid & o_pixel_ready.
  - When en=0, every stage (data and valid) holds; output is stable until taken.
  - Bubbles propagate as valid=0. Full throughput is 1 pixel/cycle when i_ready is held high.
- Config:
  - i_cfg_update takes effect for windows accepted from the next cycle on.
  - The shift and mode used by each sample travel with it through the pipeline, so in-flight samples finish with the config they entered with.
  - i_cfg_update is honoured even while stalled.
- Coefficient writes:
  - i_coef_we with i_coef_addr<=8 writes the shadow kernel; addresses 9..15 are ignored.
  - If i_coef_we and i_cfg_update occur in the same cycle, the commit uses the pre-write shadow value; the write lands in the shadow only.
- Normalise:
  - Shift s>0: y = (sum + 2^(s-1)) >>> s (arithmetic).
  - s=0: y = sum.
- Clamp:
  - y<0 gives 0; y>2^PIXEL_W-1 gives 2^PIXEL_W-1; otherwise y.
  - Each clamped output increments o_clip_count on the S3 load; the counter saturates at all-ones.
  - If a clip and i_cfg_update occur in the same cycle, the clear wins.
- The user kernel with shift 15 must not overflow the sum width; the bench checks the worst case of all coefficients -128 with pixels 255.

Decomposition:
- Package conv_pkg:
  - Mode encodings MODE_PASS/GAUSS/SHARP/USER.
  - Fixed kernel constant arrays and their shifts.
  - Function for sum width.
- One sub-module, conv3x3_cfg: holds the shadow/active kernel registers, commit logic and mode decode, and outputs the active 9xCOEF_W kernel plus shift.
- The datapath stays in conv3x3_filter.

Test Plan:
- Reset, mode 0, window centre=77, others random, i_ready=1 -> output 77 exactly 3 cycles after accept; o_clip_count=0.
- Gaussian, all pixels 100 -> 100; centre 255 and others 0 -> (1020+8)>>4 = 64.
- Sharpen, centre 255 and neighbours 0 -> clamped 255, clip count 1; centre 0 and neighbours 255 -> clamped 0, clip count 2.
- User kernel all 1 with shift 3, all pixels 8 -> 9; same window in the same cycle as an i_coef_we to addr 4 plus i_cfg_update -> old coefficient used.
- Stream 20 windows with i_ready toggling 1,0,0,1 -> outputs in order, none dropped or duplicated, data stable while stalled, o_pixel_ready low during the stall.
- Assert i_rst with 3 samples in flight -> valid drops immediately (asynchronously), no stale output after release, mode returns to passthrough.
